// File: rtl/psum_collector_pkg.sv
// psum_collector_pkg: shared types and width helpers for the psum collector.
//   state_e     - collector FSM states
//   acc_width() - accumulator width (PE psum width plus overflow guard bits)
//   sat_max()   - largest positive value of a signed word of the given width
package psum_collector_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PE,
    REQ,
    RECV,
    DRAIN,
    FIN
  } state_e;

  function automatic int unsigned acc_width(input int unsigned psum_w,
                                            input int unsigned guard_w);
    return psum_w + guard_w;
  endfunction

  function automatic longint sat_max(input int unsigned data_w);
    return (longint'(1) << (data_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/psum_collector_if.sv
// psum_collector_if: PE readout link and output stream of the psum collector.
//   clip_finish_flg / start_psum_out / psum_out / psum_out_en : PE side
//   out_data / out_valid / out_ready / out_last               : global buffer side
//   master : collector view, slave : PE + sink view
interface psum_collector_if #(
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned PSUM_DATA_WIDTH = 48
) ();

  logic                       clip_finish_flg;
  logic                       start_psum_out;
  logic [PSUM_DATA_WIDTH-1:0] psum_out;
  logic                       psum_out_en;
  logic [DATA_WIDTH-1:0]      out_data;
  logic                       out_valid;
  logic                       out_ready;
  logic                       out_last;

  modport master (
    input  clip_finish_flg, psum_out, psum_out_en, out_ready,
    output start_psum_out, out_data, out_valid, out_last
  );

  modport slave (
    output clip_finish_flg, psum_out, psum_out_en, out_ready,
    input  start_psum_out, out_data, out_valid, out_last
  );

endinterface

// File: rtl/psum_collector_round_sat.sv
// psum_round_sat: combinational output conversion of one accumulator entry.
//   acc        - signed accumulator value
//   frac_shift - arithmetic right shift, rounded half-up
//   data       - result saturated to a signed DATA_WIDTH word
//   sat        - high when the result was clamped
module psum_round_sat
  import psum_collector_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 52
) (
  input  logic signed [ACC_WIDTH-1:0] acc,
  input  logic [5:0]                  frac_shift,
  output logic [DATA_WIDTH-1:0]       data,
  output logic                        sat
);

  // One extra bit so adding the rounding constant can never wrap.
  localparam int unsigned W = ACC_WIDTH + 1;
  localparam logic signed [W-1:0] SMAX = W'(sat_max(DATA_WIDTH));
  localparam logic signed [W-1:0] SMIN = ~SMAX;

  logic signed [W-1:0] ext;
  logic signed [W-1:0] rnd;
  logic signed [W-1:0] shifted;

  always_comb begin
    ext = {acc[ACC_WIDTH-1], acc};
    rnd = '0;
    if (frac_shift != 6'd0) begin
      rnd = W'(1) << (frac_shift - 6'd1);
    end
    shifted = (ext + rnd) >>> frac_shift;
    sat     = 1'b0;
    data    = shifted[DATA_WIDTH-1:0];
    if (shifted > SMAX) begin
      data = SMAX[DATA_WIDTH-1:0];
      sat  = 1'b1;
    end else if (shifted < SMIN) begin
      data = SMIN[DATA_WIDTH-1:0];
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/psum_collector.sv
// psum_collector: reads PE psum bursts, accumulates num_pass passes, then
// streams rounded/saturated results to the global buffer.
//   clk, rst_n        - clock, asynchronous active-low reset
//   start_collect     - start pulse, latches num_psum / num_pass / frac_shift
//   pe                - PE readout link and output valid/ready stream
//   busy, done        - activity flag, end-of-job pulse
//   cfg_err           - pulse on a rejected start
//   proto_err/sat_flg - sticky stray-beat / saturation flags
module psum_collector
  import psum_collector_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned PSUM_DATA_WIDTH = 48,
  parameter int unsigned PARA_WIDTH      = 8,
  parameter int unsigned ACC_DEPTH       = 34,
  parameter int unsigned GUARD_BITS      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_collect,
  input  logic [PARA_WIDTH-1:0] num_psum,
  input  logic [PARA_WIDTH-1:0] num_pass,
  input  logic [5:0]            frac_shift,
  psum_collector_if.master      pe,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  output logic                  proto_err,
  output logic                  sat_flg
);

  localparam int unsigned ACC_WIDTH = acc_width(PSUM_DATA_WIDTH, GUARD_BITS);
  localparam int unsigned ADDR_W    = $clog2(ACC_DEPTH);
  localparam int unsigned MAX_PASS  = 1 << GUARD_BITS;

  state_e state, state_n;

  logic [PARA_WIDTH-1:0]       num_psum_q;
  logic [PARA_WIDTH-1:0]       num_pass_q;
  logic [PARA_WIDTH-1:0]       pass_cnt;
  logic [5:0]                  frac_shift_q;
  logic [ADDR_W-1:0]           addr;
  logic signed [ACC_WIDTH-1:0] acc_buf [ACC_DEPTH];

  logic                        cfg_ok;
  logic                        addr_last;
  logic                        pass_last;
  logic                        beat;
  logic                        drain_load;
  logic                        drain_hs;
  logic                        start_req;
  logic signed [ACC_WIDTH-1:0] beat_ext;
  logic signed [ACC_WIDTH-1:0] rd_acc;
  logic [DATA_WIDTH-1:0]       rs_data;
  logic                        rs_sat;

  logic [DATA_WIDTH-1:0]       out_data_q;
  logic                        out_valid_q;
  logic                        out_last_q;

  assign cfg_ok = (num_psum != '0) && (num_psum <= PARA_WIDTH'(ACC_DEPTH)) &&
                  (num_pass != '0) && (num_pass <= PARA_WIDTH'(MAX_PASS));

  assign addr_last = (PARA_WIDTH'(addr) == num_psum_q - 1'b1);
  assign pass_last = (pass_cnt == num_pass_q - 1'b1);
  assign beat      = pe.psum_out_en && (state == RECV);
  assign beat_ext  = {{GUARD_BITS{pe.psum_out[PSUM_DATA_WIDTH-1]}}, pe.psum_out};
  assign rd_acc    = acc_buf[addr];

  // A word is handed over when the sink takes it; a new one is loaded when the
  // register is empty or is being emptied this cycle (except after the last).
  assign drain_hs   = (state == DRAIN) && out_valid_q && pe.out_ready;
  assign drain_load = (state == DRAIN) && (!out_valid_q || (pe.out_ready && !out_last_q));

  psum_round_sat #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_round_sat (
    .acc        (rd_acc),
    .frac_shift (frac_shift_q),
    .data       (rs_data),
    .sat        (rs_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    start_req = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE:    if (start_collect && cfg_ok) state_n = WAIT_PE;
      WAIT_PE: if (pe.clip_finish_flg) state_n = REQ;
      REQ: begin
        start_req = 1'b1;
        state_n   = RECV;
      end
      RECV:    if (beat && addr_last) state_n = pass_last ? DRAIN : WAIT_PE;
      DRAIN:   if (drain_hs && out_last_q) state_n = FIN;
      FIN: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Accumulation buffer: contents are don't-care after reset because the
  // first pass always overwrites each entry it uses.
  always_ff @(posedge clk) begin
    if (beat) begin
      acc_buf[addr] <= (pass_cnt == '0) ? beat_ext : acc_buf[addr] + beat_ext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_psum_q   <= '0;
      num_pass_q   <= '0;
      frac_shift_q <= '0;
      pass_cnt     <= '0;
      addr         <= '0;
      cfg_err      <= 1'b0;
      proto_err    <= 1'b0;
      sat_flg      <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
    end else begin
      cfg_err <= 1'b0;

      if (state == IDLE && start_collect) begin
        if (cfg_ok) begin
          num_psum_q   <= num_psum;
          num_pass_q   <= num_pass;
          frac_shift_q <= frac_shift;
          pass_cnt     <= '0;
          proto_err    <= 1'b0;
          sat_flg      <= 1'b0;
        end else begin
          cfg_err <= 1'b1;
        end
      end

      if (pe.psum_out_en && state != RECV) begin
        proto_err <= 1'b1;
      end

      if (state == REQ) begin
        addr <= '0;
      end

      if (beat) begin
        if (addr_last) begin
          addr <= '0;
          if (!pass_last) pass_cnt <= pass_cnt + 1'b1;
        end else begin
          addr <= addr + 1'b1;
        end
      end

      // addr stops on the last entry so the buffer read stays in range.
      if (drain_hs && out_last_q) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
        out_data_q  <= '0;
      end else if (drain_load) begin
        out_data_q  <= rs_data;
        out_last_q  <= addr_last;
        out_valid_q <= 1'b1;
        if (rs_sat) sat_flg <= 1'b1;
        if (!addr_last) addr <= addr + 1'b1;
      end
    end
  end

  assign pe.start_psum_out = start_req;
  assign pe.out_data       = out_data_q;
  assign pe.out_valid      = out_valid_q;
  assign pe.out_last       = out_last_q;

endmodule

// File: tb/tb_psum_collector.sv
module tb_psum_collector;

  localparam int DW    = 16;
  localparam int PW    = 48;
  localparam int PARA  = 8;
  localparam int DEPTH = 34;
  localparam int GUARD = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start_collect = 1'b0;
  logic [PARA-1:0] num_psum = '0;
  logic [PARA-1:0] num_pass = '0;
  logic [5:0]      frac_shift = '0;
  logic            busy, done, cfg_err, proto_err, sat_flg;

  psum_collector_if #(.DATA_WIDTH(DW), .PSUM_DATA_WIDTH(PW)) bus ();

  psum_collector #(
    .DATA_WIDTH      (DW),
    .PSUM_DATA_WIDTH (PW),
    .PARA_WIDTH      (PARA),
    .ACC_DEPTH       (DEPTH),
    .GUARD_BITS      (GUARD)
  ) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_collect (start_collect),
    .num_psum      (num_psum),
    .num_pass      (num_pass),
    .frac_shift    (frac_shift),
    .pe            (bus),
    .busy          (busy),
    .done          (done),
    .cfg_err       (cfg_err),
    .proto_err     (proto_err),
    .sat_flg       (sat_flg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ready_mode = 0;
  int   pat_idx = 0;
  logic [3:0] stall_pat = 4'b1001;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference conversion: round half-up, arithmetic shift, clamp to DW bits.
  function automatic longint ref_conv(input longint a, input int fs, output bit s);
    longint r;
    r = a + ((fs > 0) ? (longint'(1) << (fs - 1)) : longint'(0));
    r = r >>> fs;
    s = 1'b0;
    if (r > 32767) begin
      r = 32767;
      s = 1'b1;
    end else if (r < -32768) begin
      r = -32768;
      s = 1'b1;
    end
    return r;
  endfunction

  function automatic longint rand48();
    logic [63:0]        raw;
    logic signed [47:0] b;
    raw = {$urandom(), $urandom()};
    b   = raw[47:0];
    b   = b >>> $urandom_range(0, 47);
    return longint'(b);
  endfunction

  // Sink readiness
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = 1'($urandom_range(0, 1));
        default: begin
          bus.out_ready = stall_pat[3 - pat_idx];
          pat_idx = (pat_idx + 1) % 4;
        end
      endcase
    end
  end

  // Monitor / scoreboard
  bit            prev_stall = 1'b0;
  bit            exp_done = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        exp_done   = 1'b0;
      end else begin
        if (exp_done) begin
          check("done_after_last", done, 1);
          exp_done = 1'b0;
        end
        if (prev_stall) begin
          check("stall_valid_hold", bus.out_valid, 1);
          check("stall_data_hold", bus.out_data, prev_data);
          check("stall_last_hold", bus.out_last, prev_last);
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got 0x%0h expected no output", bus.out_data);
          end else begin
            e = exp_q.pop_front();
            check("out_data", bus.out_data, e.data);
            check("out_last", bus.out_last, e.last);
            if (bus.out_last) exp_done = 1'b1;
          end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_data  = bus.out_data;
        prev_last  = bus.out_last;
      end
    end
  end

  task automatic start_cfg(input int np, input int npass, input int fs);
    num_psum      = PARA'(np);
    num_pass      = PARA'(npass);
    frac_shift    = 6'(fs);
    start_collect = 1'b1;
    @(posedge clk);
    #1;
    start_collect = 1'b0;
  endtask

  task automatic bad_cfg(input int np, input int npass, input string name);
    start_cfg(np, npass, 0);
    check({name, "_cfg_err"}, cfg_err, 1);
    check({name, "_busy"}, busy, 0);
    @(posedge clk);
    #1;
    check({name, "_cfg_err_pulse"}, cfg_err, 0);
    check({name, "_busy_after"}, busy, 0);
  endtask

  // kind: 0 random, 1 -(i+1), 2 10*(i+1), 3 +/-40000
  task automatic run(input int np, input int npass, input int fs, input int rmode,
                     input bit stray, input int kind);
    longint acc[DEPTH];
    longint beats[16][DEPTH];
    bit     exp_sat;
    bit     s;
    longint r;
    bit     got;
    int     first_v;
    int     done_c;
    exp_sat = 1'b0;
    for (int p = 0; p < npass; p++) begin
      for (int i = 0; i < np; i++) begin
        case (kind)
          1:       beats[p][i] = -(i + 1);
          2:       beats[p][i] = 10 * (i + 1);
          3:       beats[p][i] = (i == 0) ? 40000 : -40000;
          default: beats[p][i] = rand48();
        endcase
        acc[i] = (p == 0) ? beats[p][i] : acc[i] + beats[p][i];
      end
    end
    for (int i = 0; i < np; i++) begin
      r = ref_conv(acc[i], fs, s);
      exp_sat |= s;
      exp_q.push_back('{data: DW'(r), last: (i == np - 1)});
    end
    ready_mode = rmode;
    pat_idx    = 0;

    start_cfg(np, npass, fs);
    check("busy_after_start", busy, 1);
    check("no_cfg_err_on_legal", cfg_err, 0);

    for (int p = 0; p < npass; p++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      if (stray && p == ((npass > 1) ? 1 : 0)) begin
        bus.psum_out    = 48'h7FFF_FFFF_FFFF;
        bus.psum_out_en = 1'b1;
        @(posedge clk);
        #1;
        bus.psum_out_en = 1'b0;
        check("proto_err_on_stray", proto_err, 1);
      end
      bus.clip_finish_flg = 1'b1;
      @(posedge clk);
      #1;
      bus.clip_finish_flg = 1'b0;
      check("start_psum_out_latency", bus.start_psum_out, 1);
      @(posedge clk);
      #1;
      check("start_psum_out_one_cycle", bus.start_psum_out, 0);
      for (int i = 0; i < np; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          bus.psum_out_en = 1'b0;
          @(posedge clk);
          #1;
        end
        bus.psum_out    = 48'(beats[p][i]);
        bus.psum_out_en = 1'b1;
        @(posedge clk);
        #1;
      end
      bus.psum_out_en = 1'b0;
    end

    got     = 1'b0;
    first_v = -1;
    done_c  = 0;
    for (int c = 0; c < 600 && !got; c++) begin
      @(negedge clk);
      if (bus.out_valid && first_v < 0) first_v = c;
      if (done) begin
        got    = 1'b1;
        done_c = c;
      end
    end
    check("done_seen", got, 1);
    if (rmode == 0 && got) check("full_throughput_cycles", done_c - first_v, np);
    @(posedge clk);
    #1;
    check("busy_after_done", busy, 0);
    check("done_single_pulse", done, 0);
    check("sat_flg", sat_flg, exp_sat);
    check("proto_err", proto_err, stray);
    check("words_outstanding", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.clip_finish_flg = 1'b0;
    bus.psum_out        = '0;
    bus.psum_out_en     = 1'b0;
    rst_n = 1'b0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_proto_err", proto_err, 0);
    check("rst_sat_flg", sat_flg, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_start_psum_out", bus.start_psum_out, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run(9, 1, 0, 0, 1'b0, 1);
    run(3, 3, 2, 0, 1'b0, 2);
    run(2, 1, 0, 0, 1'b0, 3);
    run(6, 2, 3, 2, 1'b0, 0);

    bad_cfg(35, 1, "num_psum_35");
    bad_cfg(9, 0, "num_pass_0");
    bad_cfg(0, 1, "num_psum_0");
    bad_cfg(9, 17, "num_pass_17");

    run(5, 2, 4, 1, 1'b1, 0);
    run(DEPTH, 16, 47, 1, 1'b0, 0);

    // Abort mid-RECV with a reset
    ready_mode = 0;
    start_cfg(8, 1, 0);
    bus.psum_out_en = 1'b1;
    @(posedge clk);
    #1;
    bus.psum_out_en = 1'b0;
    bus.clip_finish_flg = 1'b1;
    @(posedge clk);
    #1;
    bus.clip_finish_flg = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      bus.psum_out    = 48'h0123_4567_89AB;
      bus.psum_out_en = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.psum_out_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_proto_err", proto_err, 0);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_start_psum_out", bus.start_psum_out, 0);
    check("abort_done", done, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run(4, 2, 1, 0, 1'b0, 0);

    for (int t = 0; t < 8; t++) begin
      run($urandom_range(1, DEPTH), $urandom_range(1, 16), $urandom_range(0, 47),
          $urandom_range(0, 2), 1'b0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
